// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard information in, pipeline stall/flush controls out.
// The controller uses the master modport; the pipeline side uses slave.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             ID_Jump;
    logic             EX_MemRead;
    logic [4:0]       EX_rt;
    logic             EX_BranchTaken;
    logic             Mem_busy;
    logic             Exc_req;

    logic             PC_Write;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             Pipe_Freeze;
    logic [1:0]       PC_Sel;
    logic             Exc_ack;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_Jump,
               EX_MemRead, EX_rt, EX_BranchTaken, Mem_busy, Exc_req,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze,
               PC_Sel, Exc_ack, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        output ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_Jump,
               EX_MemRead, EX_rt, EX_BranchTaken, Mem_busy, Exc_req,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze,
               PC_Sel, Exc_ack, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > exception > branch > load-use > jump.
// Controls are combinational from state and inputs; counters, timeout flag and state are registered.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int EXC_MASK    = 2,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.master bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_EXC_MASK = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        mask_q, mask_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic       load_use;
    logic       stall_ev;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, freeze, exc_ack;
    logic [1:0] pc_sel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_W'(MEM_TIMEOUT)) ? v : v + 1'b1;
    endfunction

    assign load_use = bus.EX_MemRead && (bus.EX_rt != 5'd0) &&
                      ((bus.ID_UsesRs && (bus.ID_rs == bus.EX_rt)) ||
                       (bus.ID_UsesRt && (bus.ID_rt == bus.EX_rt)));

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        freeze     = 1'b0;
        pc_sel     = 2'b00;
        exc_ack    = 1'b0;
        stall_ev   = 1'b0;
        state_d    = state_q;
        mask_d     = mask_q;
        wait_d     = wait_q;

        if (bus.Mem_busy) begin
            // Exception mask count pauses here; a pending Exc_req is simply seen again later.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            freeze     = 1'b1;
            stall_ev   = 1'b1;
            wait_d     = wait_inc(wait_q);
            if (state_q == ST_RUN) begin
                state_d = ST_MEM_WAIT;
            end
        end else begin
            wait_d = '0;
            if (state_q == ST_EXC_MASK) begin
                if (mask_q <= 4'd1) begin
                    mask_d  = 4'd0;
                    state_d = ST_RUN;
                end else begin
                    mask_d = mask_q - 4'd1;
                end
            end else begin
                state_d = ST_RUN;
            end

            if ((state_q != ST_EXC_MASK) && bus.Exc_req) begin
                pc_sel     = 2'b11;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                exc_ack    = 1'b1;
                state_d    = ST_EXC_MASK;
                mask_d     = 4'(EXC_MASK);
            end else if (bus.EX_BranchTaken) begin
                pc_sel     = 2'b10;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                stall_ev   = 1'b1;
            end else if (bus.ID_Jump) begin
                pc_sel     = 2'b01;
                ifid_flush = 1'b1;
            end
        end

        // Reset cycle presents the idle pipeline controls regardless of inputs.
        if (reset) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            freeze     = 1'b0;
            pc_sel     = 2'b00;
            exc_ack    = 1'b0;
            stall_ev   = 1'b0;
        end

        stall_d   = stall_ev ? sat_inc(stall_q) : stall_q;
        flush_d   = ifid_flush ? sat_inc(flush_q) : flush_q;
        timeout_d = timeout_q | (bus.Mem_busy && (wait_d == WAIT_W'(MEM_TIMEOUT)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            mask_q    <= 4'd0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign bus.PC_Write    = pc_write;
    assign bus.IFID_Write  = ifid_write;
    assign bus.IFID_Flush  = ifid_flush;
    assign bus.IDEX_Flush  = idex_flush;
    assign bus.Pipe_Freeze = freeze;
    assign bus.PC_Sel      = pc_sel;
    assign bus.Exc_ack     = exc_ack;
    assign bus.mem_timeout = timeout_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios, literal spot checks and a per-cycle
// reference model of the priority rules, counters, exception mask window and timeout.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W       = 4;
    localparam int EXC_MASK    = 2;
    localparam int MEM_TIMEOUT = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

    pipeline_hazard_ctrl #(
        .CNT_W(CNT_W), .EXC_MASK(EXC_MASK), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        bus.ID_rs = 5'd0; bus.ID_rt = 5'd0; bus.ID_UsesRs = 1'b0; bus.ID_UsesRt = 1'b0;
        bus.ID_Jump = 1'b0; bus.EX_MemRead = 1'b0; bus.EX_rt = 5'd0;
        bus.EX_BranchTaken = 1'b0; bus.Mem_busy = 1'b0; bus.Exc_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference model: remaining masked cycles, consecutive busy run, saturating counts.
    int m_stall = 0, m_flush = 0, m_wait = 0, m_mask = 0;
    bit m_to = 1'b0;

    initial begin
        bit lu;
        int e_pcw, e_ifw, e_iff, e_idf, e_frz, e_sel, e_ack;
        @(posedge clk);
        forever begin
            @(negedge clk);
            lu = bus.EX_MemRead && bus.EX_rt != 0 &&
                 ((bus.ID_UsesRs && bus.ID_rs == bus.EX_rt) || (bus.ID_UsesRt && bus.ID_rt == bus.EX_rt));
            e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_frz = 0; e_sel = 0; e_ack = 0;
            if (!reset) begin
                if (bus.Mem_busy) begin
                    e_pcw = 0; e_ifw = 0; e_frz = 1;
                end else if (bus.Exc_req && m_mask == 0) begin
                    e_sel = 3; e_iff = 1; e_idf = 1; e_ack = 1;
                end else if (bus.EX_BranchTaken) begin
                    e_sel = 2; e_iff = 1; e_idf = 1;
                end else if (lu) begin
                    e_pcw = 0; e_ifw = 0; e_idf = 1;
                end else if (bus.ID_Jump) begin
                    e_sel = 1; e_iff = 1;
                end
            end
            chk("m_PC_Write",    bus.PC_Write,    e_pcw);
            chk("m_IFID_Write",  bus.IFID_Write,  e_ifw);
            chk("m_IFID_Flush",  bus.IFID_Flush,  e_iff);
            chk("m_IDEX_Flush",  bus.IDEX_Flush,  e_idf);
            chk("m_Pipe_Freeze", bus.Pipe_Freeze, e_frz);
            chk("m_PC_Sel",      bus.PC_Sel,      e_sel);
            chk("m_Exc_ack",     bus.Exc_ack,     e_ack);
            chk("m_mem_timeout", bus.mem_timeout, m_to);
            chk("m_stall_cnt",   bus.stall_cnt,   m_stall);
            chk("m_flush_cnt",   bus.flush_cnt,   m_flush);

            if (reset) begin
                m_stall = 0; m_flush = 0; m_wait = 0; m_mask = 0; m_to = 1'b0;
            end else begin
                if (e_ifw == 0 && m_stall < CMAX) m_stall++;
                if (e_iff == 1 && m_flush < CMAX) m_flush++;
                if (bus.Mem_busy) begin
                    m_wait++;
                    if (m_wait >= MEM_TIMEOUT) m_to = 1'b1;
                end else begin
                    m_wait = 0;
                    if (e_ack == 1) m_mask = EXC_MASK;
                    else if (m_mask > 0) m_mask--;
                end
            end
        end
    end

    initial begin
        idle_in();
        reset = 1'b1;
        bus.Mem_busy = 1'b1;
        bus.Exc_req = 1'b1;
        tick(); tick();
        settle();
        chk("rst_pcw", bus.PC_Write, 1);
        chk("rst_frz", bus.Pipe_Freeze, 0);
        chk("rst_ack", bus.Exc_ack, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        chk("rst_to", bus.mem_timeout, 0);
        reset = 1'b0;
        idle_in();
        tick();

        // Load-use via rs
        bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd5; bus.ID_rs = 5'd5; bus.ID_UsesRs = 1'b1;
        settle();
        chk("lu_pcw", bus.PC_Write, 0);
        chk("lu_ifw", bus.IFID_Write, 0);
        chk("lu_idf", bus.IDEX_Flush, 1);
        tick();
        chk("lu_stall", bus.stall_cnt, 1);
        // r0 destination is never a hazard
        bus.EX_rt = 5'd0; bus.ID_rs = 5'd0;
        settle();
        chk("r0_pcw", bus.PC_Write, 1);
        chk("r0_idf", bus.IDEX_Flush, 0);
        tick();
        chk("r0_stall", bus.stall_cnt, 1);
        // Load-use via rt
        bus.EX_rt = 5'd9; bus.ID_rs = 5'd3; bus.ID_UsesRs = 1'b0; bus.ID_UsesRt = 1'b1; bus.ID_rt = 5'd9;
        settle();
        chk("lu_rt_ifw", bus.IFID_Write, 0);
        tick();
        chk("lu_rt_stall", bus.stall_cnt, 2);
        // Matching field that is not read
        bus.ID_UsesRt = 1'b0; bus.ID_rs = 5'd9;
        settle();
        chk("nouse_pcw", bus.PC_Write, 1);
        tick();

        // Branch overrides load-use and jump
        idle_in();
        bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd5; bus.ID_rs = 5'd5; bus.ID_UsesRs = 1'b1;
        bus.ID_Jump = 1'b1; bus.EX_BranchTaken = 1'b1;
        settle();
        chk("br_sel", bus.PC_Sel, 2);
        chk("br_iff", bus.IFID_Flush, 1);
        chk("br_idf", bus.IDEX_Flush, 1);
        chk("br_pcw", bus.PC_Write, 1);
        tick();
        chk("br_flush", bus.flush_cnt, 1);
        chk("br_stall", bus.stall_cnt, 2);
        // Load-use defers jump
        bus.EX_BranchTaken = 1'b0;
        settle();
        chk("lujmp_sel", bus.PC_Sel, 0);
        chk("lujmp_iff", bus.IFID_Flush, 0);
        tick();
        chk("lujmp_stall", bus.stall_cnt, 3);
        idle_in();
        bus.ID_Jump = 1'b1;
        settle();
        chk("jmp_sel", bus.PC_Sel, 1);
        chk("jmp_iff", bus.IFID_Flush, 1);
        chk("jmp_idf", bus.IDEX_Flush, 0);
        tick();
        chk("jmp_flush", bus.flush_cnt, 2);

        // Memory wait defers a pending exception
        idle_in();
        bus.Mem_busy = 1'b1; bus.Exc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_frz", bus.Pipe_Freeze, 1);
            chk("mw_ack", bus.Exc_ack, 0);
            tick();
        end
        chk("mw_stall", bus.stall_cnt, 6);
        chk("mw_to", bus.mem_timeout, 0);
        bus.Mem_busy = 1'b0;
        settle();
        chk("exc_ack", bus.Exc_ack, 1);
        chk("exc_sel", bus.PC_Sel, 3);
        tick();
        bus.ID_Jump = 1'b1;
        settle();
        chk("mask_ack", bus.Exc_ack, 0);
        chk("mask_sel", bus.PC_Sel, 1);
        tick();
        bus.ID_Jump = 1'b0;
        settle();
        chk("mask2_ack", bus.Exc_ack, 0);
        tick();
        settle();
        chk("reacc_ack", bus.Exc_ack, 1);
        tick();
        bus.Exc_req = 1'b0;
        repeat (3) tick();

        // Busy cycle pauses the mask window
        bus.Exc_req = 1'b1;
        tick();
        bus.Mem_busy = 1'b1;
        settle();
        chk("mp_busy_ack", bus.Exc_ack, 0);
        tick();
        bus.Mem_busy = 1'b0;
        settle();
        chk("mp_m1_ack", bus.Exc_ack, 0);
        tick();
        settle();
        chk("mp_m2_ack", bus.Exc_ack, 0);
        tick();
        settle();
        chk("mp_acc_ack", bus.Exc_ack, 1);
        tick();
        bus.Exc_req = 1'b0;
        repeat (3) tick();
        chk("mid_stall", bus.stall_cnt, 7);
        chk("mid_flush", bus.flush_cnt, 7);

        // Timeout after MEM_TIMEOUT busy cycles, sticky until reset
        bus.Mem_busy = 1'b1;
        repeat (3) tick();
        chk("to_3", bus.mem_timeout, 0);
        tick();
        chk("to_4", bus.mem_timeout, 1);
        bus.Mem_busy = 1'b0;
        tick();
        chk("to_sticky", bus.mem_timeout, 1);
        bus.Mem_busy = 1'b1;
        tick();
        reset = 1'b1;
        settle();
        chk("rstw_frz", bus.Pipe_Freeze, 0);
        chk("rstw_pcw", bus.PC_Write, 1);
        tick();
        chk("rstw_stall", bus.stall_cnt, 0);
        chk("rstw_to", bus.mem_timeout, 0);
        reset = 1'b0;
        bus.Mem_busy = 1'b0;
        settle();
        chk("post_pcw", bus.PC_Write, 1);
        chk("post_frz", bus.Pipe_Freeze, 0);
        chk("post_sel", bus.PC_Sel, 0);
        tick();

        // Counter saturation
        bus.Mem_busy = 1'b1;
        repeat (20) tick();
        chk("sat_stall", bus.stall_cnt, CMAX);
        bus.Mem_busy = 1'b0;
        bus.ID_Jump = 1'b1;
        repeat (20) tick();
        chk("sat_flush", bus.flush_cnt, CMAX);
        bus.ID_Jump = 1'b0;

        // Reset during the mask window returns to RUN
        bus.Exc_req = 1'b1;
        tick();
        reset = 1'b1;
        settle();
        chk("rstm_ack", bus.Exc_ack, 0);
        tick();
        reset = 1'b0;
        settle();
        chk("rstm_reacc", bus.Exc_ack, 1);
        tick();
        bus.Exc_req = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives write-enable and flush controls for the PC, IF/ID and ID/EX registers and the PC source select. It resolves load-use hazards, taken branches, jumps, data-memory wait states and exception entry with a fixed priority. It also maintains stall and flush performance counters and a memory-timeout flag.

Parameters:
CNT_W, 32, width of stall_cnt and flush_cnt; counters saturate at all-ones
EXC_MASK, 2, cycles after exception acceptance during which Exc_req is ignored (1..15)
MEM_TIMEOUT, 64, consecutive Mem_busy cycles before mem_timeout is set

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
ID_rs  in  5  rs field of instruction in ID
ID_rt  in  5  rt field of instruction in ID
ID_UsesRs  in  1  ID instruction reads rs
ID_UsesRt  in  1  ID instruction reads rt
ID_Jump  in  1  jump resolved in ID
EX_MemRead  in  1  EX instruction is a load
EX_rt  in  5  load destination in EX
EX_BranchTaken  in  1  branch resolved taken in EX
Mem_busy  in  1  data memory not ready this cycle
Exc_req  in  1  exception/interrupt request (level)
PC_Write  out  1  PC register write enable
IFID_Write  out  1  IF/ID write enable
IFID_Flush  out  1  IF/ID load zero instruction
IDEX_Flush  out  1  ID/EX load bubble
Pipe_Freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
PC_Sel  out  2  00 PC+4, 01 jump target, 10 branch target, 11 exception vector
Exc_ack  out  1  one-cycle acceptance pulse
mem_timeout  out  1  sticky timeout flag
stall_cnt  out  CNT_W  load-use plus memory-wait stall cycles
flush_cnt  out  CNT_W  cycles with IFID_Flush=1

Behaviour:
- Control outputs are combinational from state and inputs. Counters, mem_timeout and state are registered.
- States: RUN, MEM_WAIT, EXC_MASK_ST.
- Default (no event): PC_Write=1, IFID_Write=1, flushes=0, Pipe_Freeze=0, PC_Sel=00, Exc_ack=0.
- Priority per cycle, highest first:
  1. Mem_busy
  2. Exc_req (accepted only in RUN)
  3. EX_BranchTaken
  4. Load-use hazard
  5. ID_Jump
- Mem_busy=1 (any state):
  - PC_Write=0, IFID_Write=0, Pipe_Freeze=1, no flush, PC_Sel=00.
  - From RUN, go to MEM_WAIT.
  - stall_cnt +1 per cycle.
  - A wait counter increments each busy cycle. When it reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset.
  - A pending Exc_req is deferred, not lost.
- MEM_WAIT with Mem_busy=0: clear the wait counter, return to RUN, and evaluate the remaining priorities in this same cycle.
- Exception accept (RUN, Mem_busy=0, Exc_req=1):
  - Outputs: PC_Sel=11, PC_Write=1, IFID_Flush=1, IDEX_Flush=1, Exc_ack=1.
  - Go to EXC_MASK_ST with a mask counter loaded with EXC_MASK.
  - Branch, jump and load-use inputs are ignored in the accept cycle.
- EXC_MASK_ST: Exc_req is ignored and other events are handled normally. The mask counter decrements each non-busy cycle; at 0, return to RUN. A Mem_busy cycle pauses the count and the block stays in EXC_MASK_ST.
- EX_BranchTaken: PC_Sel=10, PC_Write=1, IFID_Flush=1, IDEX_Flush=1. This overrides any load-use hazard and any jump in the same cycle.
- Load-use hazard:
  - Condition: EX_MemRead & EX_rt!=0 & ((ID_UsesRs & ID_rs==EX_rt) | (ID_UsesRt & ID_rt==EX_rt)).
  - Outputs: PC_Write=0, IFID_Write=0, IDEX_Flush=1, PC_Sel=00; stall_cnt +1.
  - A jump in ID is not taken this cycle; it is re-evaluated next cycle.
- ID_Jump alone: PC_Sel=01, PC_Write=1, IFID_Flush=1.
- IFID_Flush=1 with IFID_Write=0 never occurs.
- flush_cnt increments on every cycle with IFID_Flush=1.
- Both counters saturate at 2^CNT_W-1.
- Reset (synchronous, wins over all inputs):
  - state=RUN; counters=0; mem_timeout=0; wait and mask counters=0.
  - Outputs during the reset cycle equal the default values, with Exc_ack=0.
  - Reset asserted mid-MEM_WAIT or mid-EXC_MASK_ST returns to RUN on the next edge.

Test Plan:
- Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5, ID_UsesRs=1 for one cycle -> PC_Write=0, IFID_Write=0, IDEX_Flush=1; stall_cnt 0->1. Same stimulus with EX_rt=0 -> defaults.
- Branch over load-use: EX_BranchTaken=1 together with a load-use hazard and ID_Jump=1 -> PC_Sel=10, IFID_Flush=1, IDEX_Flush=1, PC_Write=1; flush_cnt +1; stall_cnt unchanged.
- Memory wait: Mem_busy=1 for 3 cycles with Exc_req=1 -> Pipe_Freeze=1 and Exc_ack=0 for 3 cycles; stall_cnt=3. Cycle 4 (busy low) -> Exc_ack=1, PC_Sel=11.
- Timeout: MEM_TIMEOUT=4, Mem_busy held 4 cycles -> mem_timeout=1 after the 4th edge; stays 1 after busy drops; cleared only by reset.
- Exception mask: Exc_req held high, EXC_MASK=2 -> Exc_ack pulses exactly at cycles 0 and 3 (one accept cycle plus 2 masked cycles per acceptance). ID_Jump=1 during the mask -> PC_Sel=01.
- Reset mid-operation: reset=1 while in MEM_WAIT with stall_cnt=7 -> next edge state=RUN, stall_cnt=0, mem_timeout=0; with Mem_busy=0, outputs are defaults.
